// File: rtl/control_contador_pkg.sv
// Shared encodings for the counter command sequencer: counter modes,
// one-hot FSM states and default widths.
package control_contador_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int STEP_W_DEF = 16;

  typedef enum logic [1:0] {
    MODO_UP1   = 2'b00,
    MODO_DOWN1 = 2'b01,
    MODO_UP3   = 2'b10,
    MODO_LOAD  = 2'b11
  } modo_t;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_LOAD   = 5'b00010,
    ST_RUN    = 5'b00100,
    ST_SETTLE = 5'b01000,
    ST_REPORT = 5'b10000
  } state_t;

endpackage

// File: rtl/control_contador_cuenta_pasos.sv
// Loadable step down-counter; last is high while exactly one step remains.
module cuenta_pasos
  import control_contador_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              load,
  input  logic [STEP_W-1:0] load_value,
  input  logic              dec,
  output logic              last
);

  logic [STEP_W-1:0] count_reg;

  // Never decrements below zero, so a full-scale load cannot wrap.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign last = (count_reg == STEP_W'(1));

endmodule

// File: rtl/control_contador.sv
// Command sequencer for the cascaded counter: accepts load/count commands,
// drives ENB/MODO/ENTRADA and reports the final count and wrap-around count.
module control_contador
  import control_contador_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [WIDTH-1:0]  CMD_DATA,
  input  logic [STEP_W-1:0] CMD_STEPS,
  input  logic              ABORT,
  output logic              ENB,
  output logic [1:0]        MODO,
  output logic [WIDTH-1:0]  ENTRADA,
  input  logic [WIDTH-1:0]  SALIDA,
  input  logic              RCO,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORTED,
  output logic [WIDTH-1:0]  RESULT,
  output logic [STEP_W-1:0] WRAPS
);

  state_t             state_reg, state_next;
  modo_t              op_reg, op_next;
  modo_t              modo_reg, modo_next;
  logic               enb_reg, enb_next;
  logic [WIDTH-1:0]   entrada_reg, entrada_next;
  logic               done_reg, done_next;
  logic               aborted_reg, aborted_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [STEP_W-1:0]  wraps_reg, wraps_next;
  logic               first_run_reg, first_run_next;
  logic               accept;
  logic               step_dec;
  logic               step_last;
  logic               count_rco;

  cuenta_pasos #(
    .STEP_W(STEP_W)
  ) u_cuenta_pasos (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .load      (accept),
    .load_value(CMD_STEPS),
    .dec       (step_dec),
    .last      (step_last)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_reg     <= ST_IDLE;
      op_reg        <= MODO_UP1;
      modo_reg      <= MODO_UP1;
      enb_reg       <= 1'b0;
      entrada_reg   <= '0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
      result_reg    <= '0;
      wraps_reg     <= '0;
      first_run_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      modo_reg      <= modo_next;
      enb_reg       <= enb_next;
      entrada_reg   <= entrada_next;
      done_reg      <= done_next;
      aborted_reg   <= aborted_next;
      result_reg    <= result_next;
      wraps_reg     <= wraps_next;
      first_run_reg <= first_run_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step_dec   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (CMD_VALID) begin
          accept = 1'b1;
          if (CMD_OP == MODO_LOAD)      state_next = ST_LOAD;
          else if (CMD_STEPS != '0)     state_next = ST_RUN;
          else                          state_next = ST_SETTLE;
        end
      end
      ST_LOAD:   state_next = ST_SETTLE;
      ST_RUN: begin
        step_dec = 1'b1;
        if (ABORT || step_last) state_next = ST_SETTLE;
      end
      ST_SETTLE: state_next = ST_REPORT;
      ST_REPORT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase

    op_next        = accept ? modo_t'(CMD_OP) : op_reg;
    enb_next       = (state_next == ST_LOAD) || (state_next == ST_RUN);
    first_run_next = accept && (state_next == ST_RUN);

    modo_next = MODO_UP1;
    if (state_next == ST_LOAD)     modo_next = MODO_LOAD;
    else if (state_next == ST_RUN) modo_next = op_next;

    entrada_next = entrada_reg;
    if (state_next == ST_LOAD) entrada_next = CMD_DATA;

    // RCO in the first RUN cycle predates this command; after a load it is not a wrap.
    count_rco = ((state_reg == ST_RUN) && !first_run_reg) ||
                ((state_reg == ST_SETTLE) && (op_reg != MODO_LOAD));

    wraps_next = wraps_reg;
    if (accept)                                      wraps_next = '0;
    else if (count_rco && RCO && (wraps_reg != '1))  wraps_next = wraps_reg + 1'b1;

    aborted_next = aborted_reg;
    if (accept)                                 aborted_next = 1'b0;
    else if ((state_reg == ST_RUN) && ABORT)    aborted_next = 1'b1;

    result_next = (state_reg == ST_SETTLE) ? SALIDA : result_reg;
    done_next   = (state_next == ST_REPORT);
  end

  assign CMD_READY = (state_reg == ST_IDLE);
  assign BUSY      = (state_reg != ST_IDLE);
  assign ENB       = enb_reg;
  assign MODO      = modo_reg;
  assign ENTRADA   = entrada_reg;
  assign DONE      = done_reg;
  assign ABORTED   = aborted_reg;
  assign RESULT    = result_reg;
  assign WRAPS     = wraps_reg;

endmodule

// File: doc/control_contador.md
Name: control_contador

Overview:
- Command sequencer for the 16-bit cascaded counter.
- Accepts one command at a time (load, or count N steps in a given mode) over a valid/ready handshake.
- Drives the counter's ENB/MODO/entrada, samples salida/RCO, and reports the final count and the number of wrap-arounds.
- Sits between the system control logic and the counter instance; it is the only driver of the counter's control inputs.

Parameters:
- WIDTH, 16, counter data width (entrada/salida/RESULT).
- STEP_W, 16, width of the step-count field and of WRAPS.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_L  in  1  synchronous reset, active low.
- CMD_VALID  in  1  command request; must be held until accepted.
- CMD_READY  out  1  high in IDLE only.
- CMD_OP  in  2  00 count up 1, 01 count down 1, 10 count up 3, 11 parallel load.
- CMD_DATA  in  WIDTH  load value (OP=11 only).
- CMD_STEPS  in  STEP_W  number of enabled count cycles (OP≠11).
- ABORT  in  1  synchronous stop request, honoured in RUN only.
- ENB  out  1  counter enable.
- MODO  out  2  counter mode; same encoding as CMD_OP.
- ENTRADA  out  WIDTH  counter parallel-load data.
- SALIDA  in  WIDTH  counter output.
- RCO  in  1  counter ripple carry-out.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- ABORTED  out  1  valid with DONE; command ended by ABORT.
- RESULT  out  WIDTH  SALIDA captured in SETTLE; holds until the next SETTLE.
- WRAPS  out  STEP_W  RCO count for the last command; saturates at all-ones.

Behaviour:
- Reset:
  - RESET_L=0 at a posedge puts the FSM in IDLE.
  - ENB=0, MODO=00, ENTRADA=0, DONE=0, ABORTED=0, RESULT=0, WRAPS=0.
  - Any latched command is discarded; reset mid-RUN drops ENB on that same edge.
- Counter timing: the counter updates salida/RCO on the CLK edge at which it samples ENB=1. RCO is high for the cycle after the wrapping update.
- States: IDLE, LOAD, RUN, SETTLE, REPORT. ENB/MODO/ENTRADA are registered outputs of the FSM.
- IDLE:
  - CMD_READY=1, ENB=0.
  - Accept on a posedge with CMD_VALID=1: latch OP, DATA, STEPS and clear WRAPS/ABORTED.
  - OP=11 goes to LOAD. OP≠11 with STEPS≠0 goes to RUN. OP≠11 with STEPS=0 goes to SETTLE; ENB is never asserted.
- LOAD: exactly one cycle with ENB=1, MODO=11, ENTRADA=DATA; then SETTLE. RCO is not counted for loads.
- RUN:
  - ENB=1, MODO=OP for exactly STEPS consecutive cycles.
  - A step down-counter loads STEPS on accept and decrements each RUN cycle; on its last cycle the FSM goes to SETTLE.
  - ABORT=1 at a RUN posedge goes to SETTLE with ABORTED set. ENB is low from the next cycle, so the abort cycle's step is the last.
- WRAPS: increments at each posedge in RUN (except the edge ending the first RUN cycle) and in SETTLE where RCO=1. This counts wraps caused by every enabled step.
- SETTLE: ENB=0; RESULT captured from SALIDA at the edge leaving SETTLE; then REPORT.
- REPORT: DONE=1 for one cycle, ABORTED valid; then IDLE.
- Latency from the accept edge to DONE high:
  - count: STEPS+2 cycles.
  - load: 3 cycles.
  - STEPS=0: 2 cycles.
- Back-to-back commands: earliest re-accept is the first IDLE cycle after REPORT.
- CMD_VALID while BUSY: ignored, no side effects.
- ABORT outside RUN: ignored.
- CMD_* may change freely after acceptance.
- Maximum STEPS is 2^STEP_W−1, with no internal wrap of the step counter.

Decomposition:
- Package control_contador_pkg:
  - MODO encodings MODO_UP1=00, MODO_DOWN1=01, MODO_UP3=10, MODO_LOAD=11.
  - FSM state encoding (one-hot, 5 bits).
  - Default WIDTH/STEP_W constants.
- One sub-module, cuenta_pasos: STEP_W-bit loadable down-counter with a last-step flag. It has the same CLK/RESET_L convention.

Test Plan:
- LOAD 0x1234 -> exactly one cycle ENB=1/MODO=11/ENTRADA=0x1234; DONE 3 cycles after accept; RESULT=0x1234; WRAPS=0; ABORTED=0.
- LOAD 0xFFFE, then UP1 STEPS=3 -> exactly 3 ENB cycles with MODO=00; RESULT=0x0001; WRAPS=1; DONE at accept+5.
- LOAD 0x0001, then DOWN1 STEPS=0 -> ENB never high; DONE at accept+2; RESULT=0x0001; WRAPS=0.
- LOAD 0x0000, UP3 STEPS=100, ABORT on the 10th RUN cycle -> 10 ENB cycles; RESULT=0x001E; ABORTED=1 with DONE.
- UP1 STEPS=50, RESET_L=0 on RUN cycle 5 -> ENB=0 and BUSY=0 after that edge; CMD_READY=1 on release; RESULT=0; WRAPS=0.
- CMD_VALID held through a busy command -> second command accepted on the first IDLE cycle after DONE; no commands lost or duplicated.
